mux2to1_rr: RTL and testbench
=============================

// Module: mux2to1_rr
// PURPOSE
// - Merges two valid/ready input streams into one output stream, and tags each beat with its source.
// - Direction: counterpart of demux1to2. demux1to2 splits one stream by sel; this block recombines
//   two streams and regenerates sel as out_sel.
// - Round-robin arbitration, one registered output stage, full throughput when out_ready=1.
// PARAMETERS
// - WIDTH  8  data width of each input and of the output
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous reset, active-high
// - in0_valid  in   1      source 0 beat available
// - in0_data   in   WIDTH  source 0 payload
// - in0_last   in   1      source 0 end-of-packet (used only with MUX_PKT_LOCK_EN)
// - in0_ready  out  1      source 0 beat accepted this cycle
// - in1_valid  in   1      source 1 beat available
// - in1_data   in   WIDTH  source 1 payload
// - in1_last   in   1      source 1 end-of-packet (used only with MUX_PKT_LOCK_EN)
// - in1_ready  out  1      source 1 beat accepted this cycle
// - out_valid  out  1      output register holds a beat
// - out_data   out  WIDTH  registered payload
// - out_sel    out  1      source of the current beat (0=in0, 1=in1)
// - out_last   out  1      registered last flag of the current beat
// - out_ready  in   1      downstream accepts the beat
// BEHAVIOUR
// - Reset values (sync, rst=1 at clk edge):
//   - out_valid=0, out_data=0, out_sel=0, out_last=0
//   - priority pointer prio=0 (in0 favoured), lock=0
// - Load enable: load = !out_valid || out_ready.
// - Grant (combinational from valids, prio and lock):
//   - Only one source requests -> that source wins.
//   - Both request -> source prio wins.
//   - Neither requests -> no grant.
// - inK_ready = load && grant==K. At most one in*_ready is high per cycle.
//   - inK_ready may depend combinationally on inK_valid.
// - Transfer: inK_valid && inK_ready.
//   - Next edge: out_data<=inK_data, out_sel<=K, out_last<=inK_last, out_valid<=1.
//   - prio<=~K, so the other source gets priority next.
// - Out pop with no input transfer: out_valid && out_ready && no grant -> out_valid<=0.
//   - out_data, out_sel and out_last hold their values.
// - Latency: input accept to out_valid = 1 cycle.
// - Throughput: 1 beat/cycle when out_ready=1.
//   - Both sources continuously valid -> strict alternation 0,1,0,1 (starting from prio).
// - Backpressure: out_valid=1 && out_ready=0 ->
//   - both in*_ready=0
//   - output register stable, prio unchanged
// - Simultaneous pop and load in the same cycle: the register is replaced and out_valid stays 1.
// - Reset mid-stream: an in-flight beat in the output register is discarded.
//   - Sources must re-present any unaccepted beat.
// - No data or width arithmetic: the payload passes through unmodified.
// CONFIGURATION
// - MUX_PKT_LOCK_EN defined: packet-atomic arbitration.
//   - Transfer with inK_last=0 -> lock<=1, owner<=K.
//   - While lock=1, only owner may be granted. The other source's ready stays 0
//     even if the owner is idle.
//   - Owner transfer with last=1 -> lock<=0, prio<=~owner.
// - MUX_PKT_LOCK_EN undefined: per-beat arbitration.
//   - in*_last is ignored for arbitration.
//   - in*_last is still copied to out_last.
//   - No lock state is built.
// TESTING
// - Reset: rst=1 two cycles, all valids high ->
//   - out_valid=0, both readies 0 during reset
//   - first grant after reset goes to in0
// - Single source: in1 sends 0xA1,0xA2,0xA3, out_ready=1 ->
//   - out 0xA1,0xA2,0xA3 with out_sel=1 on consecutive cycles, 1-cycle latency
// - Contention: both sources valid for 6 cycles, in0=0x10.., in1=0x20.. ->
//   - out_sel sequence 0,1,0,1,0,1
//   - data 0x10,0x20,0x11,0x21,0x12,0x22
// - Backpressure: out_ready=0 for 3 cycles with out_valid=1 ->
//   - out_data stable, both in*_ready=0
//   - on release: next grant goes to the source indicated by prio
// - Reset mid-stream: rst=1 while out_valid=1 ->
//   - out_valid=0 next cycle, prio=0
// - MUX_PKT_LOCK_EN: in0 sends a 3-beat packet (last on beat 3), in1 valid throughout ->
//   - out_sel 0,0,0 then 1
//   - in1_ready=0 during an inserted in0 idle cycle

Source files
------------

// File: rtl/mux2to1_rr.sv
// rtl/mux2to1_rr.sv - round-robin 2:1 stream merge with source tag, registered output (optional packet lock: MUX_PKT_LOCK_EN)
module mux2to1_rr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    output logic             out_last,
    input  logic             out_ready
);

    logic prio;
    logic load;
    logic req0;
    logic req1;
    logic gnt_valid;
    logic gnt_sel;
    logic xfer;

`ifdef MUX_PKT_LOCK_EN
    logic lock;
    logic owner;

    // While a packet is in flight only its owner may request
    always_comb begin
        req0 = in0_valid && (!lock || !owner);
        req1 = in1_valid && (!lock || owner);
    end
`else
    // Per-beat arbitration: requests are the raw valids
    always_comb begin
        req0 = in0_valid;
        req1 = in1_valid;
    end
`endif

    // Round-robin grant: a lone requester wins, a tie goes to prio
    always_comb begin
        gnt_valid = req0 || req1;
        gnt_sel   = 1'b0;
        if (req0 && req1) begin
            gnt_sel = prio;
        end else if (req1) begin
            gnt_sel = 1'b1;
        end
    end

    assign load      = !out_valid || out_ready;
    assign xfer      = !rst && load && gnt_valid;
    assign in0_ready = xfer && !gnt_sel;
    assign in1_ready = xfer && gnt_sel;

    // Output register, priority pointer and (optionally) packet lock
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            out_last  <= 1'b0;
            prio      <= 1'b0;
`ifdef MUX_PKT_LOCK_EN
            lock      <= 1'b0;
            owner     <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_sel ? in1_data : in0_data;
            out_sel   <= gnt_sel;
            out_last  <= gnt_sel ? in1_last : in0_last;
            prio      <= ~gnt_sel;
`ifdef MUX_PKT_LOCK_EN
            // A non-last beat opens (or continues) a packet; a last beat closes it
            lock      <= !(gnt_sel ? in1_last : in0_last);
            owner     <= gnt_sel;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2to1_rr.sv
// tb/tb_mux2to1_rr.sv - directed self-checking bench for mux2to1_rr
module tb_mux2to1_rr;

    logic       clk;
    logic       rst;
    logic       in0_valid;
    logic [7:0] in0_data;
    logic       in0_last;
    logic       in0_ready;
    logic       in1_valid;
    logic [7:0] in1_data;
    logic       in1_last;
    logic       in1_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sel;
    logic       out_last;
    logic       out_ready;

    int checks;
    int failures;

    mux2to1_rr #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_out_valid got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h55; in0_last = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h66; in1_last = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got v=%b r0=%b r1=%b exp 0 0 0", i, out_valid, in0_ready, in1_ready);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant got r0=%b r1=%b exp r0=1 r1=0", in0_ready, in1_ready);
        end
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h55 || out_sel !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_beat got v=%b d=%h s=%b exp v=1 d=55 s=0", out_valid, out_data, out_sel);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h55 || out_sel !== 1'b0) begin
            failures++;
            $display("FAIL pop_hold got v=%b d=%h s=%b exp v=0 d=55 s=0", out_valid, out_data, out_sel);
        end
    endtask

    task automatic test_single;
        logic [7:0] vec [3];
        vec[0] = 8'hA1; vec[1] = 8'hA2; vec[2] = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            in1_valid = 1'b1;
            in1_data  = vec[i];
            #1;
            checks++;
            if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
                failures++;
                $display("FAIL single_ready beat=%0d got r0=%b r1=%b exp r0=0 r1=1", i, in0_ready, in1_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== vec[i] || out_sel !== 1'b1) begin
                failures++;
                $display("FAIL single_out beat=%0d got v=%b d=%h s=%b exp v=1 d=%h s=1", i, out_valid, out_data, out_sel, vec[i]);
            end
        end
        drain();
    endtask

    task automatic test_contention;
        logic [7:0] exp_data [6];
        logic       exp_sel  [6];
        int n0;
        int n1;
        logic g0;
        logic g1;
        exp_data[0] = 8'h10; exp_data[1] = 8'h20; exp_data[2] = 8'h11;
        exp_data[3] = 8'h21; exp_data[4] = 8'h12; exp_data[5] = 8'h22;
        exp_sel[0] = 1'b0; exp_sel[1] = 1'b1; exp_sel[2] = 1'b0;
        exp_sel[3] = 1'b1; exp_sel[4] = 1'b0; exp_sel[5] = 1'b1;
        n0 = 0;
        n1 = 0;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in0_data = 8'h10 + 8'(n0);
            in1_data = 8'h20 + 8'(n1);
            #1;
            g0 = in0_ready;
            g1 = in1_ready;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[i] || out_data !== exp_data[i]) begin
                failures++;
                $display("FAIL contention beat=%0d got v=%b s=%b d=%h exp v=1 s=%b d=%h", i, out_valid, out_sel, out_data, exp_sel[i], exp_data[i]);
            end
            if (g0 === 1'b1) n0++;
            if (g1 === 1'b1) n1++;
        end
        drain();
    endtask

    task automatic test_backpressure;
        in0_valid = 1'b1; in0_data = 8'h30;
        in1_valid = 1'b1; in1_data = 8'h40;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h30 || out_sel !== 1'b0) begin
            failures++;
            $display("FAIL bp_first got v=%b d=%h s=%b exp v=1 d=30 s=0", out_valid, out_data, out_sel);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready cyc=%0d got r0=%b r1=%b exp 0 0", i, in0_ready, in1_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h30 || out_sel !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h s=%b exp v=1 d=30 s=0", i, out_valid, out_data, out_sel);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in0_ready !== 1'b0 || in1_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_grant got r0=%b r1=%b exp r0=0 r1=1", in0_ready, in1_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h40 || out_sel !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_beat got v=%b d=%h s=%b exp v=1 d=40 s=1", out_valid, out_data, out_sel);
        end
        drain();
    endtask

    task automatic test_reset_mid;
        in0_valid = 1'b1; in0_data = 8'h77;
        tick();
        in0_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            failures++;
            $display("FAIL rmid_load got v=%b d=%h exp v=1 d=77", out_valid, out_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_discard got v=%b exp v=0", out_valid);
        end
        in0_valid = 1'b1; in0_data = 8'h78;
        in1_valid = 1'b1; in1_data = 8'h88;
        #1;
        checks++;
        if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rmid_prio got r0=%b r1=%b exp r0=1 r1=0", in0_ready, in1_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h78 || out_sel !== 1'b0) begin
            failures++;
            $display("FAIL rmid_beat got v=%b d=%h s=%b exp v=1 d=78 s=0", out_valid, out_data, out_sel);
        end
        drain();
    endtask

    task automatic test_last;
        // prio points at in1 here; a lone in1 beat with last=1 hands priority back to in0
        in1_valid = 1'b1; in1_data = 8'h90; in1_last = 1'b1;
        tick();
        in1_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h90 || out_sel !== 1'b1 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL last_copy got v=%b d=%h s=%b l=%b exp v=1 d=90 s=1 l=1", out_valid, out_data, out_sel, out_last);
        end
`ifdef MUX_PKT_LOCK_EN
        in1_valid = 1'b1; in1_data = 8'h91; in1_last = 1'b1;
        in0_valid = 1'b1; in0_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                in0_valid = 1'b0;
                #1;
                checks++;
                if (in1_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL lock_idle_ready got r1=%b exp 0", in1_ready);
                end
                tick();
                in0_valid = 1'b1;
            end
            in0_data = 8'hB0 + 8'(i);
            in0_last = (i == 2);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 1'b0 || out_data !== (8'hB0 + 8'(i)) || out_last !== (i == 2)) begin
                failures++;
                $display("FAIL lock_beat=%0d got v=%b s=%b d=%h l=%b exp s=0 d=%h", i, out_valid, out_sel, out_data, out_last, 8'hB0 + 8'(i));
            end
        end
        in0_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 1'b1 || out_data !== 8'h91) begin
            failures++;
            $display("FAIL lock_release got v=%b s=%b d=%h exp v=1 s=1 d=91", out_valid, out_sel, out_data);
        end
`else
        in0_valid = 1'b1; in0_data = 8'hB0; in0_last = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h91; in1_last = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 1'b0 || out_data !== 8'hB0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL nolock_beat0 got v=%b s=%b d=%h l=%b exp v=1 s=0 d=b0 l=0", out_valid, out_sel, out_data, out_last);
        end
        in0_data = 8'hB1;
        #1;
        checks++;
        if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
            failures++;
            $display("FAIL nolock_switch got r0=%b r1=%b exp r0=0 r1=1", in0_ready, in1_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 1'b1 || out_data !== 8'h91 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL nolock_beat1 got v=%b s=%b d=%h l=%b exp v=1 s=1 d=91 l=1", out_valid, out_sel, out_data, out_last);
        end
`endif
        in0_last = 1'b0;
        in1_last = 1'b0;
        drain();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in0_valid = 1'b0; in0_data = 8'h00; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = 8'h00; in1_last = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_last();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
